// File: rtl/fft_out_serializer_if.sv
// Sample stream from the FFT output serializer to its consumer.
//
// Handshake: a sample moves on a rising clock edge where out_valid and
// out_ready are both high. Once out_valid is high, it stays high until that
// transfer happens. out_data, out_index and out_last stay constant until the
// transfer happens. out_ready may change at any time and does not depend on
// out_valid.
interface fft_out_serializer_if #(
  parameter int N   = 16,
  parameter int MSB = 16
);
  localparam int IW = $clog2(N);

  logic           out_valid;
  logic           out_ready;
  logic [MSB-1:0] out_data;
  logic [IW-1:0]  out_index;
  logic           out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Captures a finished FFT frame from the flat parallel result bus and streams
// it out one sample per transfer, in natural or bit-reversed slot order.
// A new frame is accepted only when idle, or on the same edge as the final
// transfer of the current frame. Any other frame-done edge is dropped and
// sets the sticky overrun flag.
module fft_out_serializer #(
  parameter int N      = 16,
  parameter int MSB    = 16,
  parameter int BITREV = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calc_finish,
  input  logic [N*MSB-1:0]     fft_data_in,
  fft_out_serializer_if.master out_if,
  output logic                 busy,
  output logic                 overrun,
  output logic                 dbg_state
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic           fin_q, fin_d;
  logic           last_q, last_d;
  logic           ovr_q, ovr_d;
  logic [MSB-1:0] shadow_q [N];
  logic [MSB-1:0] shadow_d [N];

  logic           fin_edge;
  logic           xfer;
  logic           final_xfer;
  logic           load;
  logic [IW-1:0]  sel_idx;

  // Reverse the bit order of a position index over IW bits.
  function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) begin
      r[i] = v[IW-1-i];
    end
    return r;
  endfunction

  assign fin_edge   = calc_finish & ~fin_q;
  assign xfer       = (state_q == S_STREAM) & out_if.out_ready;
  assign final_xfer = xfer & (cnt_q == LAST_IDX);

  // Next state: frame capture, position advance, overrun detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fin_d    = calc_finish;
    ovr_d    = ovr_q;
    shadow_d = shadow_q;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fin_edge) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (final_xfer) begin
          cnt_d = '0;
          // A frame that completes exactly as the last sample leaves is
          // taken without a bubble. Otherwise the block goes back to idle.
          if (fin_edge) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (xfer) begin
            cnt_d = cnt_q + IW'(1);
          end
          if (fin_edge) begin
            ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      for (int k = 0; k < N; k++) begin
        shadow_d[k] = fft_data_in[k*MSB +: MSB];
      end
    end

    last_d = (state_d == S_STREAM) && (cnt_d == LAST_IDX);
  end

  // State, counter and shadow registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      last_q   <= last_d;
      ovr_q    <= ovr_d;
      shadow_q <= shadow_d;
    end
  end

  // out_data comes only from flops: the registered counter picks a registered
  // shadow slot, so no input reaches the output through logic.
  assign sel_idx          = (BITREV != 0) ? bit_rev(cnt_q) : cnt_q;
  assign out_if.out_data  = shadow_q[sel_idx];
  assign out_if.out_valid = (state_q == S_STREAM);
  assign out_if.out_index = cnt_q;
  assign out_if.out_last  = last_q;
  assign busy             = (state_q == S_STREAM);
  assign overrun          = ovr_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer. Two instances (natural and bit-reversed order)
// share all inputs. A queue-based model predicts every output on every cycle.
module tb_fft_out_serializer;
  localparam int N   = 16;
  localparam int MSB = 16;
  localparam int IW  = $clog2(N);
  localparam int W   = N * MSB;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         fin;
  logic         ready;
  logic [W-1:0] data_in;
  logic         busy0, ovr0, st0;
  logic         busy1, ovr1, st1;

  always #5 clk = ~clk;

  fft_out_serializer_if #(.N(N), .MSB(MSB)) if0 ();
  fft_out_serializer_if #(.N(N), .MSB(MSB)) if1 ();
  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  fft_out_serializer #(.N(N), .MSB(MSB), .BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .calc_finish(fin), .fft_data_in(data_in),
    .out_if(if0), .busy(busy0), .overrun(ovr0), .dbg_state(st0)
  );

  fft_out_serializer #(.N(N), .MSB(MSB), .BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .calc_finish(fin), .fft_data_in(data_in),
    .out_if(if1), .busy(busy1), .overrun(ovr1), .dbg_state(st1)
  );

  // ---------------- reference model / scoreboard ----------------
  // Each queue holds the samples of the held frame that have not left yet.
  // Its head is the sample on the bus now.
  logic [MSB-1:0] exp0_q[$];
  logic [MSB-1:0] exp1_q[$];
  logic           m_prev;
  logic           m_ovr;
  int             checks;
  int             errors;

  function automatic int bitrev(input int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < IW; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] make_frame(input logic [MSB-1:0] base);
    logic [W-1:0] f;
    for (int k = 0; k < N; k++) f[k*MSB +: MSB] = base + MSB'(k);
    return f;
  endfunction

  function automatic logic [W-1:0] rand_frame();
    logic [W-1:0] f;
    for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // Drive one cycle of inputs, advance the model across the rising edge and
  // compare every output on the falling edge that follows.
  task automatic step(input logic s_rst, input logic s_ready, input logic s_fin,
                      input logic [W-1:0] s_data);
    int sz;
    logic [IW+3:0] e_ctrl, o_ctrl0, o_ctrl1;
    logic e_v;
    rst     = s_rst;
    ready   = s_ready;
    fin     = s_fin;
    data_in = s_data;
    if (s_rst) begin
      exp0_q.delete();
      exp1_q.delete();
      m_ovr  = 1'b0;
      m_prev = 1'b0;
    end else begin
      if (exp0_q.size() > 0 && s_ready) begin
        void'(exp0_q.pop_front());
        void'(exp1_q.pop_front());
      end
      if (s_fin && !m_prev) begin
        if (exp0_q.size() == 0) begin
          for (int k = 0; k < N; k++) begin
            exp0_q.push_back(s_data[k*MSB +: MSB]);
            exp1_q.push_back(s_data[bitrev(k)*MSB +: MSB]);
          end
        end else begin
          m_ovr = 1'b1;
        end
      end
      m_prev = s_fin;
    end
    @(posedge clk);
    @(negedge clk);
    sz      = exp0_q.size();
    e_v     = (sz > 0);
    e_ctrl  = {e_v, e_v, e_v, m_ovr, (sz == 1), (e_v ? IW'(N - sz) : IW'(0))};
    o_ctrl0 = {if0.out_valid, busy0, st0, ovr0, if0.out_last, if0.out_index};
    o_ctrl1 = {if1.out_valid, busy1, st1, ovr1, if1.out_last, if1.out_index};
    checks++;
    if (o_ctrl0 !== e_ctrl) begin
      errors++;
      $display("FAIL sb_ctrl0 t=%0t got %b exp %b (valid,busy,state,ovr,last,index)", $time, o_ctrl0, e_ctrl);
    end
    checks++;
    if (o_ctrl1 !== e_ctrl) begin
      errors++;
      $display("FAIL sb_ctrl1 t=%0t got %b exp %b (valid,busy,state,ovr,last,index)", $time, o_ctrl1, e_ctrl);
    end
    if (e_v) begin
      checks++;
      if (if0.out_data !== exp0_q[0]) begin
        errors++;
        $display("FAIL sb_data0 t=%0t got %h exp %h", $time, if0.out_data, exp0_q[0]);
      end
      checks++;
      if (if1.out_data !== exp1_q[0]) begin
        errors++;
        $display("FAIL sb_data1 t=%0t got %h exp %h", $time, if1.out_data, exp1_q[0]);
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, rand_frame());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rand_frame());
    checks++;
    if ({if0.out_data, if1.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", if0.out_data, if1.out_data);
    end
  endtask

  task automatic test_basic();
    step(1'b0, 1'b1, 1'b1, make_frame(16'h1000));
    for (int i = 0; i < N; i++) begin
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== 16'h1000 + 16'(i) ||
          if0.out_index !== IW'(i) || if0.out_last !== (i == N - 1)) begin
        errors++;
        $display("FAIL basic_nat i=%0d got v%b d%h x%0d l%b exp d%h", i, if0.out_valid,
                 if0.out_data, if0.out_index, if0.out_last, 16'h1000 + 16'(i));
      end
      checks++;
      if (if1.out_data !== 16'h1000 + 16'(bitrev(i))) begin
        errors++;
        $display("FAIL basic_rev i=%0d got %h exp %h", i, if1.out_data, 16'h1000 + 16'(bitrev(i)));
      end
      step(1'b0, 1'b1, 1'b0, rand_frame());
    end
    checks++;
    if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_valid got %b/%b exp 0/0", if0.out_valid, if1.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, 1'b1, make_frame(16'h1000));
    for (int i = 0; i < N - 1; i++) step(1'b0, 1'b1, 1'b0, rand_frame());
    step(1'b0, 1'b1, 1'b1, make_frame(16'h2000));
    checks++;
    if (if0.out_valid !== 1'b1 || if0.out_index !== '0 || if0.out_data !== 16'h2000 ||
        if1.out_data !== 16'h2000 || ovr0 !== 1'b0 || ovr1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got v%b x%0d d%h/%h ovr%b%b exp v1 x0 d2000/2000 ovr00",
               if0.out_valid, if0.out_index, if0.out_data, if1.out_data, ovr0, ovr1);
    end
    drain(N + 1);
  endtask

  task automatic test_overrun();
    int seen2 = 0;
    step(1'b0, 1'b1, 1'b1, make_frame(16'h1000));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, rand_frame());
    step(1'b0, 1'b1, 1'b1, make_frame(16'h2000));
    for (int i = 0; i < 2 * N && if0.out_valid; i++) begin
      if (if0.out_data[15:12] == 4'h2 || if1.out_data[15:12] == 4'h2) seen2++;
      step(1'b0, 1'b1, 1'b0, rand_frame());
    end
    checks++;
    if (seen2 != 0 || if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drop got seen2=%0d valid=%b exp 0/0", seen2, if0.out_valid);
    end
    drain(5);
    checks++;
    if (ovr0 !== 1'b1 || ovr1 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got %b%b exp 11", ovr0, ovr1);
    end
  endtask

  task automatic test_backpressure();
    int n_xfer = 0;
    int ph = 0;
    logic r;
    logic [MSB-1:0] pd;
    logic [IW-1:0] px;
    step(1'b1, 1'b0, 1'b0, rand_frame());
    step(1'b0, 1'b1, 1'b1, rand_frame());
    for (int i = 0; i < 100 && if0.out_valid; i++) begin
      r  = (ph == 0);
      ph = (ph + 1) % 3;
      pd = if0.out_data;
      px = if0.out_index;
      if (r) n_xfer++;
      step(1'b0, r, 1'b0, rand_frame());
      if (!r) begin
        checks++;
        if (if0.out_data !== pd || if0.out_index !== px) begin
          errors++;
          $display("FAIL bp_stall got d%h x%0d exp d%h x%0d", if0.out_data, if0.out_index, pd, px);
        end
      end
    end
    checks++;
    if (n_xfer != N || if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count got %0d valid=%b exp %0d valid=0", n_xfer, if0.out_valid, N);
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 1'b0, rand_frame());
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), rand_frame());
    end
    drain(3 * N);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] f;
    step(1'b1, 1'b0, 1'b0, rand_frame());
    step(1'b0, 1'b1, 1'b1, make_frame(16'h1000));
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, rand_frame());
    step(1'b1, 1'b1, 1'b0, rand_frame());
    checks++;
    if ({if0.out_valid, if0.out_data, if0.out_index, if0.out_last, busy0, ovr0,
         if1.out_valid, if1.out_data, if1.out_index, if1.out_last, busy1, ovr1} !== '0) begin
      errors++;
      $display("FAIL rst_mid got v%b d%h x%0d l%b b%b / v%b d%h exp all 0", if0.out_valid,
               if0.out_data, if0.out_index, if0.out_last, busy0, if1.out_valid, if1.out_data);
    end
    f = rand_frame();
    step(1'b0, 1'b1, 1'b1, f);
    checks++;
    if (if0.out_index !== '0 || if0.out_data !== f[MSB-1:0] || if1.out_data !== f[MSB-1:0]) begin
      errors++;
      $display("FAIL rst_fresh got x%0d d%h/%h exp x0 d%h", if0.out_index, if0.out_data,
               if1.out_data, f[MSB-1:0]);
    end
    drain(N + 1);
  endtask

  task automatic test_fin_high_at_reset();
    logic [W-1:0] f;
    f = rand_frame();
    step(1'b1, 1'b1, 1'b1, f);
    step(1'b1, 1'b1, 1'b1, f);
    step(1'b0, 1'b0, 1'b1, f);
    checks++;
    if (if0.out_valid !== 1'b1 || if0.out_index !== '0 || if0.out_data !== f[MSB-1:0]) begin
      errors++;
      $display("FAIL fin_at_rst got v%b x%0d d%h exp v1 x0 d%h", if0.out_valid,
               if0.out_index, if0.out_data, f[MSB-1:0]);
    end
    drain(N + 1);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    m_prev  = 1'b0;
    m_ovr   = 1'b0;
    rst     = 1'b1;
    fin     = 1'b0;
    ready   = 1'b0;
    data_in = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_fin_high_at_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
